// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes, opcodes,
// FSM state encoding and a sign-extension range helper.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_LI = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  localparam logic [6:0]  OPC_LUI     = 7'h37;
  localparam logic [6:0]  OPC_OPIMM   = 7'h13;
  localparam logic [6:0]  OPC_OP      = 7'h33;
  localparam logic [6:0]  OPC_STORE   = 7'h23;
  localparam logic [6:0]  OPC_BRANCH  = 7'h63;
  localparam logic [6:0]  OPC_JAL     = 7'h6F;
  localparam logic [2:0]  FUNCT3_ADDI = 3'b000;
  localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;

  // True when bits [31:lsb] are all copies of the sign bit, i.e. the value
  // fits a signed field whose top bit sits at position lsb.
  function automatic logic all_same(input logic [31:0] v, input int lsb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= lsb && v[i] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Places a full signed immediate into its I/S/B/U/J instruction bit positions
// and reports whether the value is representable in that format.
module imm_pack
  import instr_encoder_pkg::*;
(
  input  fmt_e        i_fmt,
  input  logic [31:0] i_imm,
  output logic [31:0] o_bits,
  output logic        o_range_ok
);

  always_comb begin
    o_bits     = 32'h0;
    o_range_ok = 1'b1;
    case (i_fmt)
      FMT_I: begin
        o_bits     = {i_imm[11:0], 20'b0};
        o_range_ok = all_same(i_imm, 11);
      end
      FMT_S: begin
        o_bits     = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
        o_range_ok = all_same(i_imm, 11);
      end
      FMT_B: begin
        o_bits     = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
        o_range_ok = all_same(i_imm, 12) && !i_imm[0];
      end
      FMT_U: begin
        o_bits     = {i_imm[31:12], 12'b0};
        o_range_ok = (i_imm[11:0] == 12'h0);
      end
      FMT_J: begin
        o_bits     = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
        o_range_ok = all_same(i_imm, 20) && !i_imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: one registered output word, LI expanded into
// LUI+ADDI with the ADDI word parked in a pending register.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iValid,
  output logic        oReady,
  input  logic [2:0]  iFmt,
  input  logic [6:0]  iOpcode,
  input  logic [4:0]  iRd,
  input  logic [4:0]  iRs1,
  input  logic [4:0]  iRs2,
  input  logic [2:0]  iFunct3,
  input  logic [6:0]  iFunct7,
  input  logic [31:0] iImm,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oInstr,
  output logic        oErr,
  output logic        oLast,
  output logic [1:0]  oDbgState
);

  // Handshake: a request is taken on iValid && oReady, a word leaves on
  // oValid && iReady; oReady depends combinationally on iReady in S_ONE.

  state_e      r_state;
  logic [31:0] r_instr;
  logic        r_err;
  logic        r_last;
  logic [31:0] r_pend;

  state_e      w_next;
  logic        w_load_new;
  logic        w_load_pend;
  fmt_e        w_fmt;
  fmt_e        w_pack_fmt;
  logic        w_li;
  logic        w_li_two;
  logic [31:0] w_pack_imm;
  logic [31:0] w_bits_a;
  logic        w_ok_a;
  logic [31:0] w_bits_b;
  logic        w_ok_b;
  logic [31:0] w_word;
  logic        w_word_err;
  logic [31:0] w_addi;

  // pack_b always sees iImm as an I immediate: it decides whether LI fits a
  // single ADDI and also supplies the low-12 bits of the trailing ADDI.
  assign w_fmt      = fmt_e'(iFmt);
  assign w_li       = (w_fmt == FMT_LI);
  assign w_li_two   = w_li && !w_ok_b && (iImm[11:0] != 12'h0);
  assign w_pack_fmt = w_li ? (w_ok_b ? FMT_I : FMT_U) : w_fmt;
  assign w_pack_imm = (w_li && !w_ok_b) ? (iImm + 32'h0000_0800) : iImm;
  assign w_addi     = w_bits_b | {12'b0, iRd, FUNCT3_ADDI, iRd, OPC_OPIMM};

  imm_pack u_pack_a (
    .i_fmt      (w_pack_fmt),
    .i_imm      (w_pack_imm),
    .o_bits     (w_bits_a),
    .o_range_ok (w_ok_a)
  );

  imm_pack u_pack_b (
    .i_fmt      (FMT_I),
    .i_imm      (iImm),
    .o_bits     (w_bits_b),
    .o_range_ok (w_ok_b)
  );

  always_comb begin
    w_word_err = 1'b0;
    case (w_fmt)
      FMT_I:        w_word = w_bits_a | {12'b0, iRs1, iFunct3, iRd, iOpcode};
      FMT_S, FMT_B: w_word = w_bits_a | {7'b0, iRs2, iRs1, iFunct3, 5'b0, iOpcode};
      FMT_U, FMT_J: w_word = w_bits_a | {20'b0, iRd, iOpcode};
      FMT_LI:       w_word = w_ok_b ? (w_bits_a | {12'b0, 5'd0, FUNCT3_ADDI, iRd, OPC_OPIMM})
                                    : (w_bits_a | {20'b0, iRd, OPC_LUI});
      default:      w_word = {iFunct7, iRs2, iRs1, iFunct3, iRd, iOpcode};
    endcase
    if (!w_li && !w_ok_a) begin
      w_word     = INSTR_NOP;
      w_word_err = 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_load_new  = 1'b0;
    w_load_pend = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (iValid) begin
          w_load_new = 1'b1;
          w_next     = w_li_two ? S_TWO : S_ONE;
        end
      end
      S_ONE: begin
        if (iReady) begin
          if (iValid) begin
            w_load_new = 1'b1;
            w_next     = w_li_two ? S_TWO : S_ONE;
          end else begin
            w_next = S_EMPTY;
          end
        end
      end
      S_TWO: begin
        if (iReady) begin
          w_load_pend = 1'b1;
          w_next      = S_ONE;
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state <= S_EMPTY;
      r_instr <= 32'h0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
      r_pend  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_load_new) begin
        r_instr <= w_word;
        r_err   <= w_word_err;
        r_last  <= !w_li_two;
        r_pend  <= w_addi;
      end else if (w_load_pend) begin
        r_instr <= r_pend;
        r_err   <= 1'b0;
        r_last  <= 1'b1;
      end
    end
  end

  assign oReady    = (r_state == S_EMPTY) || ((r_state == S_ONE) && iReady);
  assign oValid    = (r_state != S_EMPTY);
  assign oInstr    = r_instr;
  assign oErr      = r_err;
  assign oLast     = r_last;
  assign oDbgState = r_state;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a vector table of single requests plus
// hand sequences for stall, back-to-back streaming and reset mid-expansion.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        iCLK;
  logic        iRST_n;
  logic        iValid;
  logic        oReady;
  logic [2:0]  iFmt;
  logic [6:0]  iOpcode;
  logic [4:0]  iRd;
  logic [4:0]  iRs1;
  logic [4:0]  iRs2;
  logic [2:0]  iFunct3;
  logic [6:0]  iFunct7;
  logic [31:0] iImm;
  logic        oValid;
  logic        iReady;
  logic [31:0] oInstr;
  logic        oErr;
  logic        oLast;
  logic [1:0]  oDbgState;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  instr_encoder dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iValid    (iValid),
    .oReady    (oReady),
    .iFmt      (iFmt),
    .iOpcode   (iOpcode),
    .iRd       (iRd),
    .iRs1      (iRs1),
    .iRs2      (iRs2),
    .iFunct3   (iFunct3),
    .iFunct7   (iFunct7),
    .iImm      (iImm),
    .oValid    (oValid),
    .iReady    (iReady),
    .oInstr    (oInstr),
    .oErr      (oErr),
    .oLast     (oLast),
    .oDbgState (oDbgState)
  );

  // clock / reset
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input fmt_e fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm, input int n,
                              input logic [31:0] w0, input logic [31:0] w1, input logic err);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3;
    v.f7 = f7; v.imm = imm; v.n = n; v.w0 = w0; v.w1 = w1; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    iFmt = fmt; iOpcode = op; iRd = rd; iRs1 = rs1; iRs2 = rs2;
    iFunct3 = f3; iFunct7 = f7; iImm = imm;
  endtask

  // Send one table entry with iReady held high and check every word it yields.
  task automatic run_vec(input int k);
    vec_t v;
    logic [31:0] e;
    v = vecs[k];
    exp_q.push_back(v.w0);
    if (v.n == 2) exp_q.push_back(v.w1);
    @(negedge iCLK);
    drive(v.fmt, v.op, v.rd, v.rs1, v.rs2, v.f3, v.f7, v.imm);
    iValid = 1'b1;
    iReady = 1'b1;
    check($sformatf("v%0d ready_idle", k), {31'b0, oReady}, 32'd1);
    @(negedge iCLK);
    iValid = 1'b0;
    for (int w = 0; w < v.n; w++) begin
      if (w > 0) @(negedge iCLK);
      e = exp_q.pop_front();
      check($sformatf("v%0d w%0d valid", k, w), {31'b0, oValid}, 32'd1);
      check($sformatf("v%0d w%0d instr", k, w), oInstr, e);
      check($sformatf("v%0d w%0d err", k, w), {31'b0, oErr}, {31'b0, v.err});
      check($sformatf("v%0d w%0d last", k, w), {31'b0, oLast}, (w == v.n - 1) ? 32'd1 : 32'd0);
    end
    @(negedge iCLK);
    check($sformatf("v%0d drained", k), {31'b0, oValid}, 32'd0);
  endtask

  initial begin
    // fmt      op     rd  rs1 rs2 f3 f7     imm            n  w0             w1             err
    vecs[0]  = mk(FMT_I,  7'h13, 5, 0, 31, 0, 7'h7F, 32'hFFFF_FFFF, 1, 32'hFFF0_0293, 32'h0, 1'b0);
    vecs[1]  = mk(FMT_I,  7'h13, 5, 0, 0,  0, 7'h00, 32'h0000_07FF, 1, 32'h7FF0_0293, 32'h0, 1'b0);
    vecs[2]  = mk(FMT_I,  7'h13, 5, 0, 0,  0, 7'h00, 32'h0000_0800, 1, 32'h0000_0013, 32'h0, 1'b1);
    vecs[3]  = mk(FMT_B,  7'h63, 0, 1, 2,  0, 7'h00, 32'h0000_0008, 1, 32'h0020_8463, 32'h0, 1'b0);
    vecs[4]  = mk(FMT_B,  7'h63, 0, 1, 2,  0, 7'h00, 32'h0000_0003, 1, 32'h0000_0013, 32'h0, 1'b1);
    vecs[5]  = mk(FMT_B,  7'h63, 0, 1, 2,  0, 7'h00, 32'h0000_1000, 1, 32'h0000_0013, 32'h0, 1'b1);
    vecs[6]  = mk(FMT_B,  7'h63, 0, 1, 2,  0, 7'h00, 32'h0000_0FFE, 1, 32'h7E20_8FE3, 32'h0, 1'b0);
    vecs[7]  = mk(FMT_B,  7'h63, 0, 1, 2,  0, 7'h00, 32'hFFFF_F000, 1, 32'h8020_8063, 32'h0, 1'b0);
    vecs[8]  = mk(FMT_S,  7'h23, 0, 1, 2,  2, 7'h00, 32'hFFFF_FFFC, 1, 32'hFE20_AE23, 32'h0, 1'b0);
    vecs[9]  = mk(FMT_U,  7'h37, 5, 0, 0,  0, 7'h00, 32'hABCD_E000, 1, 32'hABCD_E2B7, 32'h0, 1'b0);
    vecs[10] = mk(FMT_U,  7'h37, 5, 0, 0,  0, 7'h00, 32'h0000_0123, 1, 32'h0000_0013, 32'h0, 1'b1);
    vecs[11] = mk(FMT_J,  7'h6F, 1, 0, 0,  0, 7'h00, 32'h0000_0800, 1, 32'h0010_00EF, 32'h0, 1'b0);
    vecs[12] = mk(FMT_J,  7'h6F, 1, 0, 0,  0, 7'h00, 32'hFFF0_0000, 1, 32'h8000_00EF, 32'h0, 1'b0);
    vecs[13] = mk(FMT_J,  7'h6F, 1, 0, 0,  0, 7'h00, 32'h0010_0000, 1, 32'h0000_0013, 32'h0, 1'b1);
    vecs[14] = mk(FMT_LI, 7'h7F, 1, 0, 0,  0, 7'h00, 32'h0000_1000, 1, 32'h0000_10B7, 32'h0, 1'b0);
    vecs[15] = mk(FMT_LI, 7'h7F, 1, 0, 0,  0, 7'h00, 32'hFFFF_FFFB, 1, 32'hFFB0_0093, 32'h0, 1'b0);
    vecs[16] = mk(FMT_LI, 7'h7F, 1, 0, 0,  0, 7'h00, 32'h0000_0800, 2, 32'h0000_10B7, 32'h8000_8093, 1'b0);
    vecs[17] = mk(FMT_LI, 7'h7F, 1, 0, 0,  0, 7'h00, 32'hFFFF_F7FF, 2, 32'hFFFF_F0B7, 32'h7FF0_8093, 1'b0);
    vecs[18] = mk(FMT_R,  7'h33, 3, 1, 2,  0, 7'h00, 32'h0000_DEAD, 1, 32'h0020_81B3, 32'h0, 1'b0);
    vecs[19] = mk(FMT_R,  7'h33, 3, 1, 2,  0, 7'h20, 32'h0000_0000, 1, 32'h4020_81B3, 32'h0, 1'b0);

    iRST_n = 1'b0;
    iValid = 1'b0;
    iReady = 1'b0;
    drive(FMT_R, 7'h0, 0, 0, 0, 0, 7'h0, 32'h0);
    #12;
    check("rst ready",  {31'b0, oReady}, 32'd1);
    check("rst valid",  {31'b0, oValid}, 32'd0);
    check("rst instr",  oInstr, 32'h0);
    check("rst err",    {31'b0, oErr}, 32'd0);
    check("rst last",   {31'b0, oLast}, 32'd0);
    check("rst state",  {30'b0, oDbgState}, {30'b0, S_EMPTY});
    @(negedge iCLK);
    iRST_n = 1'b1;

    for (int k = 0; k < NV; k++) run_vec(k);

    // LI with the first word stalled for three cycles
    @(negedge iCLK);
    drive(FMT_LI, 7'h00, 10, 0, 0, 0, 7'h0, 32'h1234_5FFF);
    iValid = 1'b1;
    iReady = 1'b0;
    @(negedge iCLK);
    iValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall instr", oInstr, 32'h1234_6537);
      check("stall last",  {31'b0, oLast}, 32'd0);
      check("stall valid", {31'b0, oValid}, 32'd1);
      check("stall ready", {31'b0, oReady}, 32'd0);
      check("stall state", {30'b0, oDbgState}, {30'b0, S_TWO});
      @(negedge iCLK);
    end
    iReady = 1'b1;
    #1;
    check("two ready w/ iReady", {31'b0, oReady}, 32'd0);
    @(negedge iCLK);
    check("stall w1 instr", oInstr, 32'hFFF5_0513);
    check("stall w1 last",  {31'b0, oLast}, 32'd1);
    check("stall w1 err",   {31'b0, oErr}, 32'd0);
    check("stall w1 ready", {31'b0, oReady}, 32'd1);
    @(negedge iCLK);
    check("stall drained", {31'b0, oValid}, 32'd0);

    // back-to-back R-type, rd varied so a stale word would be visible
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLK);
      if (i > 0) begin
        check("b2b valid", {31'b0, oValid}, 32'd1);
        check("b2b instr", oInstr, 32'h0020_8033 | (32'(i + 2) << 7));
      end
      drive(FMT_R, 7'h33, 5'(i + 3), 1, 2, 0, 7'h0, 32'h0);
      iValid = 1'b1;
      iReady = 1'b1;
      #1;
      check("b2b ready", {31'b0, oReady}, 32'd1);
    end
    @(negedge iCLK);
    check("b2b last instr", oInstr, 32'h0020_8033 | (32'd7 << 7));
    iValid = 1'b0;
    @(negedge iCLK);
    check("b2b drained", {31'b0, oValid}, 32'd0);

    // reset while the LUI word is held and ADDI pending
    @(negedge iCLK);
    drive(FMT_LI, 7'h00, 10, 0, 0, 0, 7'h0, 32'h1234_5FFF);
    iValid = 1'b1;
    iReady = 1'b0;
    @(negedge iCLK);
    iValid = 1'b0;
    check("pre-rst state", {30'b0, oDbgState}, {30'b0, S_TWO});
    iRST_n = 1'b0;
    #1;
    check("mid-rst valid", {31'b0, oValid}, 32'd0);
    check("mid-rst instr", oInstr, 32'h0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    #1;
    check("post-rst valid", {31'b0, oValid}, 32'd0);
    @(negedge iCLK);
    drive(FMT_I, 7'h13, 5, 0, 0, 0, 7'h0, 32'hFFFF_FFFF);
    iValid = 1'b1;
    iReady = 1'b1;
    @(negedge iCLK);
    iValid = 1'b0;
    check("post-rst instr", oInstr, 32'hFFF0_0293);
    check("post-rst last",  {31'b0, oLast}, 32'd1);
    @(negedge iCLK);
    check("post-rst drained", {31'b0, oValid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: converts decoded fields (format, opcode, registers, funct3/funct7, full 32-bit immediate) into a 32-bit instruction word. It is the inverse of the core's immediate generator: it places immediate bits into the I/S/B/U/J positions, range-checks them, and expands the `LI` pseudo-op into `LUI`+`ADDI`. It sits between the debug/boot program-buffer writer and instruction memory. Valid/ready on both sides, one registered output word.

## Interface
- No parameters.
- `iCLK` in 1: clock.
- `iRST_n` in 1: asynchronous reset, active-low.
- `iValid` in 1: upstream request valid.
- `oReady` out 1: encoder can accept a request this cycle.
- `iFmt` in 3: FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_LI.
- `iOpcode` in 7: opcode field. Ignored for FMT_LI.
- `iRd`, `iRs1`, `iRs2` in 5 each: register fields.
- `iFunct3` in 3, `iFunct7` in 7: function fields.
- `iImm` in 32: full signed immediate value, not pre-shifted.
- `oValid` out 1: output word valid.
- `iReady` in 1: downstream accepts the word.
- `oInstr` out 32: encoded instruction.
- `oErr` out 1: immediate out of range or misaligned for `iFmt`.
- `oLast` out 1: final word of this request.

## Operation
**Handshake**
- A request is accepted when `iValid && oReady`.
- A word is consumed when `oValid && iReady`.

**States**
- S_EMPTY: no word held.
- S_ONE: holding a final word.
- S_TWO: holding a LUI word, with the ADDI word pending internally.

**Ready**
- `oReady = (state==S_EMPTY) || (state==S_ONE && iReady)`.
- This is a combinational path from `iReady`, which is permitted.

**Transitions**
- Accept with one-word result → S_ONE.
- Accept with two-word result → S_TWO.
- S_TWO consumed → S_ONE, loading the pending ADDI word.
- S_ONE consumed with no accept → S_EMPTY.

**Encoding**
- R: {f7, rs2, rs1, f3, rd, op}.
- I: imm[11:0].
- S: imm[11:5] / imm[4:0].
- B: imm[12|10:5] / imm[4:1|11].
- U: imm[31:12].
- J: imm[20|10:1|11|19:12].

**Range checks** (signed `iImm`)
- I, S: −2048..2047.
- B: −4096..4094 and imm[0]==0.
- J: −2^20..2^20−2 and imm[0]==0.
- U: imm[11:0]==0.
- On violation: single word 0x00000013 (NOP) with `oErr=1`, `oLast=1`.

**FMT_LI expansion**
- `iImm` in −2048..2047: single `ADDI rd,x0,imm`.
- Otherwise `hi = (iImm + 0x800) >> 12` (logical, 20 bits, wraps).
  - Emit `LUI rd,hi`.
  - Then, if imm[11:0] != 0, emit `ADDI rd,rd,imm[11:0]`.
- Each LI word has `oErr=0`.
- `oLast=1` only on the final word.

**Output behaviour**
- `oInstr`, `oErr` and `oLast` are registered.
- They hold stable while `oValid && !iReady`.

## Timing
- Reset state: S_EMPTY, `oValid=0`, `oInstr=0`, `oErr=0`, `oLast=0`, pending word cleared.
- `oReady=1` during reset, because the state is S_EMPTY.
- Latency: accept at edge N gives `oValid` after edge N.
- Second LI word: appears the cycle after the first word is consumed.
- Throughput:
  - One word per cycle under continuous `iReady`.
  - LI with two words blocks input for one extra cycle.
- Simultaneous consume and accept in S_ONE: the new word replaces the old one in the same edge, with no bubble.
- Reset asserted mid-expansion: the pending ADDI is discarded, and after release the state is S_EMPTY.
- `iReady` low in S_TWO: the LUI word is held and `oReady=0`.

## Structure
- Shared package (`config.v`) holds:
  - FMT_* codes.
  - Existing OPC_* constants, including OPC_LUI and OPC_OPIMM.
  - FUNCT3_ADDI.
  - NOP constant 32'h00000013.
- One combinational sub-module, `imm_pack`:
  - Inputs: fmt and imm.
  - Outputs: placed immediate bits (32) and `range_ok`.
  - Reused for both LI words.
- The top level holds the FSM, the output register and the pending register.

## Test plan
- I-type ADDI x5,x0,imm=0xFFFFFFFF (op 0x13) → `oInstr=0xFFF00293`, `oErr=0`, `oLast=1`, one cycle after accept.
- B-type BEQ x1,x2,imm=8 (op 0x63) → `0x00208463`.
- The same request with imm=3 or imm=4096 → `0x00000013`, `oErr=1`.
- FMT_LI rd=10, imm=0x12345FFF → `0x12346537` (`oLast=0`), then `0xFFF50513` (`oLast=1`).
  - Hold `iReady=0` for 3 cycles on the first word: word stays stable and `oReady=0`.
- FMT_LI rd=1, imm=0x00001000 → single `0x000010B7`, `oLast=1`.
- FMT_LI rd=1, imm=−5 → single `0xFFB00093`.
- Back-to-back R-type ADD x3,x1,x2 (op 0x33) with `iReady=1` → `0x002081B3` every cycle, with no bubbles.
- Reset mid-expansion: assert `iRST_n=0` while in S_TWO → `oValid=0` immediately.
  - After release, the first new request is emitted with no stale ADDI before it.
